// File: rtl/div_sub_shift_pkg.sv
// rtl/div_sub_shift_pkg.sv - shared widths, iteration count and FSM encoding for the divider
package div_sub_shift_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int ITER       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/sign_mag.sv
// rtl/sign_mag.sv - conditional two's-complement negation (signed<->magnitude)
module sign_mag #(
    parameter int W = 8
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/div_sub_shift.sv
// rtl/div_sub_shift.sv - 16/8 signed restoring divider, one subtract per clock
module div_sub_shift
    import div_sub_shift_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] A,
    input  logic [DIVISOR_W-1:0]  B,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  busy,
    output logic                  done,
    output logic                  dbz,
    output logic                  ovf
);

    state_e                  state_q;
    logic [15:0]             cnt_q;
    logic [DIVIDEND_W:0]     dvd_q;
    logic [DIVISOR_W:0]      rem_q;
    logic [DIVISOR_W-1:0]    bmag_q;
    logic                    sa_q, sb_q, bzero_q, ovfc_q;
    logic [DIVIDEND_W-1:0]   q_q;
    logic [DIVISOR_W-1:0]    r_q;
    logic                    done_q, dbz_q, ovf_q;

    logic [DIVIDEND_W:0]     a_mag;
    logic [DIVISOR_W-1:0]    b_mag;
    logic [DIVIDEND_W-1:0]   q_signed;
    logic [DIVISOR_W-1:0]    r_signed;

    sign_mag #(.W(DIVIDEND_W + 1)) u_a_mag (.val_i({A[DIVIDEND_W-1], A}), .neg_i(A[DIVIDEND_W-1]), .res_o(a_mag));
    sign_mag #(.W(DIVISOR_W))      u_b_mag (.val_i(B), .neg_i(B[DIVISOR_W-1]), .res_o(b_mag));
    sign_mag #(.W(DIVIDEND_W))     u_q_out (.val_i(dvd_q[DIVIDEND_W-1:0]), .neg_i(sa_q ^ sb_q), .res_o(q_signed));
    sign_mag #(.W(DIVISOR_W))      u_r_out (.val_i(rem_q[DIVISOR_W-1:0]), .neg_i(sa_q), .res_o(r_signed));

    // Single trial subtractor; quotient bits shift into the vacated dividend LSBs.
    logic [DIVISOR_W+1:0]    shifted;
    logic [DIVISOR_W+1:0]    diff;
    logic                    take;
    logic [DIVISOR_W:0]      rem_d;
    logic [DIVIDEND_W:0]     dvd_d;

    assign shifted = {rem_q, dvd_q[DIVIDEND_W-1]};
    assign diff    = shifted - {2'b00, bmag_q};
    assign take    = shifted >= {2'b00, bmag_q};
    assign rem_d   = take ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    assign dvd_d   = {dvd_q[DIVIDEND_W-1:0], take};

    logic unused_bits;
    assign unused_bits = ^{diff[DIVISOR_W+1], dvd_q[DIVIDEND_W], rem_q[DIVISOR_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            bmag_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
            ovfc_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dvd_q   <= a_mag;
                        bmag_q  <= b_mag;
                        sa_q    <= A[DIVIDEND_W-1];
                        sb_q    <= B[DIVISOR_W-1];
                        bzero_q <= (B == '0);
                        ovfc_q  <= (A == 16'h8000) && (B == 8'hFF);
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(ITER - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (bzero_q) begin
                        q_q   <= '0;
                        r_q   <= '0;
                        dbz_q <= 1'b1;
                        ovf_q <= 1'b0;
                    end else begin
                        q_q   <= q_signed;
                        r_q   <= r_signed;
                        dbz_q <= 1'b0;
                        ovf_q <= ovfc_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_sub_shift.sv
// tb/tb_div_sub_shift.sv - scoreboard bench for the signed restoring divider
module tb_div_sub_shift;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] A;
    logic [7:0]  B;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        busy, done, dbz, ovf;

    div_sub_shift dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                int qi, bi, ri, ai;
                e = sb.pop_front();
                check("Q", Q, e.q);
                check("R", R, e.r);
                check("dbz", dbz, e.dbz);
                check("ovf", ovf, e.ovf);
                check("latency", cyc - e.issue, 17);
                if (!e.dbz && !e.ovf) begin
                    qi = int'($signed(Q));
                    ri = int'($signed(R));
                    bi = int'($signed(e.b));
                    ai = int'($signed(e.a));
                    check("identity", qi * bi + ri, ai);
                    check("rem_bound", ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)) ? 1 : 0, 1);
                    check("rem_sign", (ri == 0 || ((ri < 0) == (ai < 0))) ? 1 : 0, 1);
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                            input logic [7:0] r, input logic dz, input logic ov);
        sb.push_back('{a, b, q, r, dz, ov, cyc + 1});
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic run_div(input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                           input logic [7:0] r, input logic dz, input logic ov);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        push_exp(a, b, q, r, dz, ov);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #3;
        check("rst_Q", Q, 0);
        check("rst_R", R, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_div(16'd100, 8'd7, 16'd14, 8'd2, 0, 0);
        run_div(-16'sd100, 8'd7, 16'hFFF2, 8'hFE, 0, 0);
        run_div(16'd1000, -8'sd3, 16'hFEB3, 8'd1, 0, 0);
        run_div(16'h8000, 8'hFF, 16'h8000, 8'd0, 0, 1);
        run_div(16'h8000, 8'h80, 16'd256, 8'd0, 0, 0);
        run_div(16'd5, 8'd0, 16'd0, 8'd0, 1, 0);
        run_div(16'd7, 8'd2, 16'd3, 8'd1, 0, 0);
        run_div(-16'sd7, 8'd2, 16'hFFFD, 8'hFF, 0, 0);
        run_div(16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 0, 0);
        run_div(16'h8000, 8'd1, 16'h8000, 8'd0, 0, 0);
        run_div(16'h8000, 8'd127, 16'hFEFE, 8'hFE, 0, 0);

        // second start mid-calculation must be dropped, operands ignored
        @(negedge clk);
        A = 16'd100; B = 8'd7; start = 1'b1;
        push_exp(16'd100, 8'd7, 16'd14, 8'd2, 0, 0);
        @(negedge clk);
        start = 1'b0;
        check("busy_calc", busy, 1);
        repeat (4) @(negedge clk);
        A = -16'sd5; B = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("hold_Q", Q, 16'd14);
        check("hold_R", R, 8'd2);
        check("idle_busy", busy, 0);

        // reset mid-calculation: outputs clear at once, no done afterwards
        @(negedge clk);
        A = 16'd1000; B = 8'd7; start = 1'b1;
        push_exp(16'd1000, 8'd7, 16'd142, 8'd6, 0, 0);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_Q", Q, 0);
        check("abort_R", R, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        run_div(16'd1000, 8'd7, 16'd142, 8'd6, 0, 0);

        // start held high: back-to-back operations 18 edges apart
        @(negedge clk);
        A = 16'd50; B = 8'd6; start = 1'b1;
        push_exp(16'd50, 8'd6, 16'd8, 8'd2, 0, 0);
        repeat (18) @(negedge clk);
        A = -16'sd50; B = -8'sd6;
        push_exp(-16'sd50, -8'sd6, 16'd8, 8'hFE, 0, 0);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] a;
            logic [7:0]  b;
            int ai, bi;
            a = 16'($urandom);
            b = 8'($urandom_range(1, 255));
            if (a == 16'h8000 && b == 8'hFF) b = 8'hFE;
            ai = int'($signed(a));
            bi = int'($signed(b));
            run_div(a, b, 16'(ai / bi), 8'(ai % bi), 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_sub_shift.md
DIV_SUB_SHIFT -- requirements
Module: div_sub_shift

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 The module SHALL have port A, input, 16 bits: signed two's-complement dividend.
REQ-005 The module SHALL have port B, input, 8 bits: signed two's-complement divisor.
REQ-006 The module SHALL have port Q, output reg, 16 bits: signed quotient, truncated toward zero.
REQ-007 The module SHALL have port R, output reg, 8 bits: signed remainder, carrying the sign of the dividend.
REQ-008 The module SHALL have port busy, output, 1 bit: high while in CALC or FIX.
REQ-009 The module SHALL have port done, output reg, 1 bit: single-cycle pulse when Q, R, dbz and ovf update.
REQ-010 The module SHALL have port dbz, output reg, 1 bit: the last division had divisor zero.
REQ-011 The module SHALL have port ovf, output reg, 1 bit: the last division was -32768 / -1.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and FIX, and SHALL start in IDLE after reset.
REQ-013 In IDLE with start=1 at an edge (E0), the block SHALL:
- latch |A| (17-bit magnitude) and |B| (8-bit magnitude);
- latch sign bits sA=A[15] and sB=B[7];
- clear the 16-bit iteration counter;
- clear the 9-bit partial remainder;
- enter CALC.
REQ-014 Each CALC edge SHALL perform one restoring step:
- shift {partial remainder, dividend magnitude} left by 1;
- trial-subtract |B| from the partial remainder;
- if the result is non-negative, keep it and set quotient LSB = 1;
- otherwise restore and set quotient LSB = 0.
REQ-015 CALC SHALL last exactly 16 edges (E1..E16), then enter FIX.
REQ-016 At the FIX edge (E17), the block SHALL:
- set Q = sA^sB ? −qmag : qmag;
- set R = sA ? −rmag : rmag;
- set done=1;
- return to IDLE.
done SHALL clear at the next edge.
REQ-017 Latency from the start sample edge to done high SHALL be a fixed 17 edges, independent of operand values.
REQ-018 When B==0, the block SHALL still run the full 17-edge sequence, and at FIX SHALL drive Q=0, R=0, dbz=1, ovf=0.
REQ-019 When A==16'h8000 and B==8'hFF, the block SHALL drive Q=16'h8000, R=0, ovf=1, dbz=0.
REQ-020 Every other completed division SHALL drive dbz=0 and ovf=0.
REQ-021 Magnitude arithmetic SHALL be 17 bits wide so that |−32768| and |−128| are represented without wrap.
REQ-022 |R| SHALL always be < |B|, and R SHALL fit in 8 bits for all non-zero B.
REQ-023 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 A and B SHALL be sampled only at E0; changes during CALC or FIX SHALL have no effect.
REQ-025 Q, R, dbz and ovf SHALL hold their values from one done until the next done or reset.
REQ-026 start held high continuously SHALL start a new division in the cycle after done, i.e. back-to-back operations every 18 edges.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge:
- force state to IDLE;
- set Q=0, R=0, done=0, dbz=0, ovf=0, busy=0;
- clear the counter and internal registers.
REQ-028 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no done pulse; the first start after reset release SHALL behave per REQ-013.

Structure
REQ-029 A shared package SHALL hold:
- the state encoding (2-bit IDLE/CALC/FIX);
- DIVIDEND_W=16 and DIVISOR_W=8;
- ITER=16.
REQ-030 A single sub-module, sign_mag, SHALL be instantiated for two's-complement-to-magnitude conversion (on input) and magnitude-to-signed conversion (on output), parameterised by width.
REQ-031 The datapath SHALL use one subtractor, iterated; there SHALL be no unrolled array and no use of the "/" or "%" operators.

Verification
REQ-032 Directed scenario: A=100, B=7, start pulse -> done 17 edges later; Q=14, R=2, dbz=0, ovf=0.
REQ-033 Directed scenario: A=−100, B=7 -> Q=16'hFFF2 (−14), R=8'hFE (−2); then A=1000, B=−3 -> Q=16'hFEB3 (−333), R=1.
REQ-034 Directed scenario: A=16'h8000, B=8'hFF -> Q=16'h8000, R=0, ovf=1; then A=−32768, B=−128 -> Q=256, R=0, ovf=0.
REQ-035 Directed scenario: A=5, B=0 -> Q=0, R=0, dbz=1 after 17 edges; the next valid division clears dbz.
REQ-036 Directed scenario: start re-pulsed at E5 with different A/B -> ignored, first result unchanged; rst_n low at E8 -> outputs 0 at once, no done; a fresh start after release completes normally.
REQ-037 Randomized scenario: 1000 random A/B pairs with B≠0, excluding the REQ-019 case, checked against a reference model of Q*B+R==A with |R|<|B|, sign(R)=sign(A) or R=0, and latency exactly 17.
